weight_stream_mem: RTL and testbench

Parametrised multi-lane weight store for one neuron layer, the successor to the single-word random-access weight memory. It holds num_weight entries, each num_lanes words of data_width bits. An internal burst engine streams consecutive entries to the MAC array over a valid/ready interface with back-pressure. A lane-masked write port allows weights to be reloaded at runtime.

---
 rtl/weight_stream_mem.sv | 131 +++++++++++++
 tb/tb_weight_stream_mem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_mem.sv
// Multi-lane weight store with a burst engine that streams consecutive entries
// over valid/ready through a 2-entry skid buffer; lane-masked runtime reload.
module weight_stream_mem #(
  parameter string weight_file   = "",
  parameter int    data_width    = 16,
  parameter int    num_lanes     = 4,
  parameter int    num_weight    = 8,
  parameter int    address_width = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            w_en,
  input  logic [address_width-1:0]        w_add,
  input  logic [num_lanes-1:0]            w_mask,
  input  logic [num_lanes*data_width-1:0] w_in,
  input  logic                            start,
  input  logic [address_width-1:0]        base_add,
  input  logic [address_width:0]          burst_len,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [num_lanes*data_width-1:0] o_data,
  output logic                            o_last,
  output logic [address_width-1:0]        o_idx
);
  localparam int          AW = address_width;
  localparam logic [AW:0] NW = (AW+1)'(num_weight);

  typedef logic [num_lanes-1:0][data_width-1:0] entry_t;
  typedef struct packed {
    entry_t        data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  entry_t mem [num_weight];

  // Storage is deliberately not reset so weights survive rst_n.
  always @(posedge clk) begin
    if (w_en && ({1'b0, w_add} < NW)) begin
      for (int i = 0; i < num_lanes; i++)
        if (w_mask[i]) mem[w_add][i] <= w_in[i*data_width +: data_width];
    end
  end

  state_t        state;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_cnt, len_q;
  entry_t        rd_data;
  logic [AW-1:0] rd_idx;
  logic          rd_last, rd_vld;
  beat_t         slot [2];
  logic          head;
  logic [1:0]    cnt;

  logic          pop, issue, issue_last;
  logic [1:0]    occ;
  logic [AW-1:0] next_addr;

  assign o_valid    = (cnt != 2'd0);
  assign o_data     = slot[head].data;
  assign o_idx      = slot[head].idx;
  assign o_last     = o_valid && slot[head].last;
  assign pop        = o_valid && o_ready;
  // Buffered plus in-flight beats; a read may issue if the slot frees this cycle.
  assign occ        = cnt + 2'(rd_vld);
  assign issue      = (state == READ) && ((occ - 2'(pop)) < 2'd2);
  assign issue_last = (rd_cnt == len_q - 1'b1);
  assign next_addr  = ({1'b0, rd_addr} == NW - 1'b1) ? '0 : rd_addr + 1'b1;

  // Read-first: a same-cycle write to this entry lands after the sample.
  always_ff @(posedge clk) begin
    if (issue) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_addr <= '0;
      rd_cnt  <= '0;
      len_q   <= '0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
      rd_last <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
      head    <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      rd_vld <= issue;
      if (issue) begin
        rd_idx  <= rd_addr;
        rd_last <= issue_last;
        rd_addr <= next_addr;
        rd_cnt  <= rd_cnt + 1'b1;
      end
      // At push time at most one slot is held, so the free slot is head^cnt[0].
      if (rd_vld) slot[head ^ cnt[0]] <= '{data: rd_data, idx: rd_idx, last: rd_last};
      if (pop) head <= ~head;
      cnt <= cnt + 2'(rd_vld) - 2'(pop);
      case (state)
        IDLE: if (start) begin
          if ({1'b0, base_add} >= NW) err <= 1'b1;
          else if (burst_len == '0) done <= 1'b1;
          else begin
            state   <= READ;
            busy    <= 1'b1;
            rd_addr <= base_add;
            rd_cnt  <= '0;
            len_q   <= burst_len;
          end
        end
        READ: if (issue && issue_last) state <= DRAIN;
        DRAIN: if (pop && o_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_stream_mem.sv
// Bench for weight_stream_mem: vector table of bursts, directed corner cases and
// random bursts checked against a queue-based model of the stored entries.
module tb_weight_stream_mem;
  localparam int DW = 16, NL = 4, NW = 8, AW = 3, BW = NL*DW, NW2 = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_en;
  logic [AW-1:0] w_add;
  logic [NL-1:0] w_mask;
  logic [BW-1:0] w_in;
  logic          start;
  logic [AW-1:0] base_add;
  logic [AW:0]   burst_len;
  logic          busy, done, err, o_valid, o_ready, o_last;
  logic [BW-1:0] o_data;
  logic [AW-1:0] o_idx;

  logic          w_en2, start2, busy2, done2, err2, o_valid2, o_ready2, o_last2;
  logic [AW-1:0] w_add2, base2, o_idx2;
  logic [NL-1:0] w_mask2;
  logic [BW-1:0] w_in2, o_data2;
  logic [AW:0]   len2;

  always #5 clk = ~clk;

  weight_stream_mem #(.weight_file(""), .data_width(DW), .num_lanes(NL),
                      .num_weight(NW), .address_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_add(w_add), .w_mask(w_mask), .w_in(w_in),
    .start(start), .base_add(base_add), .burst_len(burst_len), .busy(busy), .done(done),
    .err(err), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .o_idx(o_idx));

  weight_stream_mem #(.weight_file(""), .data_width(DW), .num_lanes(NL),
                      .num_weight(NW2), .address_width(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en2), .w_add(w_add2), .w_mask(w_mask2), .w_in(w_in2),
    .start(start2), .base_add(base2), .burst_len(len2), .busy(busy2), .done(done2),
    .err(err2), .o_valid(o_valid2), .o_ready(o_ready2), .o_data(o_data2), .o_last(o_last2),
    .o_idx(o_idx2));

  typedef struct {
    int            idx;
    logic [BW-1:0] data;
    bit            last;
  } exp_t;

  typedef struct {
    int base; int len; int mode; bit bstart; int first; int last;
  } vec_t;

  int            errors = 0, checks = 0;
  logic [DW-1:0] mdl [NW][NL];
  logic [BW-1:0] seen [NW];
  logic [BW-1:0] last_data;
  int            first_idx, last_idx;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] entry(input int k);
    logic [BW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = mdl[k][i];
    return r;
  endfunction

  task automatic do_write(input int a, input logic [NL-1:0] m, input logic [BW-1:0] d);
    @(negedge clk);
    w_en = 1'b1; w_add = AW'(a); w_mask = m; w_in = d;
    @(negedge clk);
    w_en = 1'b0;
    if (a < NW) for (int i = 0; i < NL; i++) if (m[i]) mdl[a][i] = d[i*DW +: DW];
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_burst(input int base, input int len, input int mode,
                           input bit coll, input bit bstart, input int abort_at);
    exp_t          q[$];
    exp_t          e;
    int            beats = 0, dones = 0;
    bit            fin = 0, stall = 0;
    logic [BW-1:0] pd, cd;
    logic [AW-1:0] pi;
    logic          pl;
    cd = 64'hC0DE_BEEF_1234_5678;
    for (int k = 0; k < len; k++) begin
      e.idx = (base + k) % NW; e.data = entry(e.idx); e.last = (k == len - 1);
      q.push_back(e);
    end
    first_idx = -1; last_idx = -1;
    @(negedge clk);
    start = 1'b1; base_add = AW'(base); burst_len = (AW+1)'(len); o_ready = 1'b1;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0; w_en = 1'b0;
      if (coll && c == 1) begin
        w_en = 1'b1; w_add = AW'(base); w_mask = '1; w_in = cd;
        for (int i = 0; i < NL; i++) mdl[base][i] = cd[i*DW +: DW];
      end
      if (bstart && c == 3) begin start = 1'b1; base_add = 3'd2; burst_len = 4'd3; end
      case (mode)
        0:       o_ready = 1'b1;
        1:       o_ready = (c % 4 == 0) || (c % 4 == 3);
        default: o_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, pd);
        chk("stall_idx", o_idx, pi);
        chk("stall_last", o_last, pl);
      end
      if (c == 1) chk("busy_after_start", busy, (len > 0) ? 1 : 0);
      if (len > 0 && c == 2) chk("first_beat_not_early", o_valid, 0);
      if (len > 0 && c == 3) chk("first_beat_latency", o_valid, 1);
      if (err) chk("no_spurious_err", err, 0);
      if (done) begin
        dones++; fin = 1;
        chk("done_after_all_beats", beats, len);
      end
      if (o_valid && o_ready) begin
        if (q.size() == 0) chk("extra_beat", o_valid && o_ready, 0);
        else begin
          e = q.pop_front();
          chk("beat_idx", o_idx, e.idx);
          chk("beat_data", o_data, e.data);
          chk("beat_last", o_last, e.last);
          if (first_idx < 0) first_idx = int'(o_idx);
          last_idx = int'(o_idx);
          seen[o_idx] = o_data;
          last_data = o_data;
          beats++;
        end
      end
      stall = o_valid && !o_ready; pd = o_data; pi = o_idx; pl = o_last;
      if (abort_at > 0 && beats == abort_at) break;
    end
    if (abort_at > 0) begin
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid", o_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_idx", o_idx, 0);
      chk("reset_data", o_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (done || o_valid) chk("quiet_after_abort", done || o_valid, 0);
      end
      chk("abort_beats", beats, abort_at);
      return;
    end
    chk("burst_finished", fin, 1);
    chk("beats_accepted", beats, len);
    chk("done_count", dones, 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
    chk("idle_valid", o_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   idxs[$];
    bit   got;
    vecs[0] = '{0, 8, 0, 0, 0, 7};
    vecs[1] = '{6, 4, 0, 0, 6, 1};
    vecs[2] = '{0, 8, 1, 0, 0, 7};
    vecs[3] = '{0, 8, 2, 0, 0, 7};
    vecs[4] = '{7, 0, 0, 0, -1, -1};
    vecs[5] = '{1, 5, 2, 1, 1, 5};
    vecs[6] = '{5, 12, 2, 0, 5, 0};

    rst_n = 1'b0; w_en = 0; w_add = 0; w_mask = 0; w_in = 0; start = 0;
    base_add = 0; burst_len = 0; o_ready = 0;
    w_en2 = 0; w_add2 = 0; w_mask2 = 0; w_in2 = 0; start2 = 0; base2 = 0; len2 = 0;
    o_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", o_data, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy2", busy2, 0);
    rst_n = 1'b1;

    for (int k = 0; k < NW; k++)
      do_write(k, '1, {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)});

    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, 0, vecs[v].bstart, 0);
      if (vecs[v].len > 0) begin
        chk("vec_first_idx", first_idx, vecs[v].first);
        chk("vec_last_idx", last_idx, vecs[v].last);
      end
      if (v == 0) chk("entry5_data", seen[5], {16'd23, 16'd22, 16'd21, 16'd20});
    end

    do_write(3, 4'b0101, {4{16'hFFFF}});
    run_burst(3, 1, 0, 0, 0, 0);
    chk("masked_write", last_data, {16'd15, 16'hFFFF, 16'd13, 16'hFFFF});

    run_burst(2, 1, 0, 1, 0, 0);
    chk("collision_old", last_data, {16'd11, 16'd10, 16'd9, 16'd8});
    run_burst(2, 1, 0, 0, 0, 0);
    chk("collision_new", last_data, 64'hC0DE_BEEF_1234_5678);

    @(negedge clk);
    start2 = 1'b1; base2 = 3'd6; len2 = 4'd3;
    @(negedge clk);
    start2 = 1'b0;
    chk("err_pulse", err2, 1);
    chk("err_busy", busy2, 0);
    chk("err_no_done", done2, 0);
    @(negedge clk);
    chk("err_width", err2, 0);
    chk("err_busy_later", busy2, 0);
    chk("err_no_beat", o_valid2, 0);

    start2 = 1'b1; base2 = 3'd5; len2 = 4'd2;
    @(negedge clk);
    start2 = 1'b0;
    chk("nw6_busy", busy2, 1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (o_valid2 && o_ready2) idxs.push_back(int'(o_idx2));
      if (done2) got = 1;
    end
    chk("nw6_done", got, 1);
    chk("nw6_beats", idxs.size(), 2);
    if (idxs.size() == 2) begin
      chk("nw6_idx0", idxs[0], 5);
      chk("nw6_idx1_wrap", idxs[1], 0);
    end

    run_burst(0, 8, 0, 0, 0, 3);
    run_burst(0, 8, 2, 0, 0, 0);
    chk("mem_kept_after_reset", seen[3], {16'd15, 16'hFFFF, 16'd13, 16'hFFFF});

    repeat (8) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, NW-1), NL'($urandom), {$urandom, $urandom});
      run_burst($urandom_range(0, NW-1), $urandom_range(1, 12), 2, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
